lcd_frame_capture: RTL
======================

// Module: lcd_frame_capture
// PURPOSE
// - Sink for the PPU LCD pixel stream (lcd_hsync/lcd_vsync/lcd_pixel/lcd_color).
// - Packs 2bpp pixels 4-per-byte into a framebuffer write port.
// - Sits between the PPU display outputs and the scan-out/debug framebuffer RAM.
// - Flags malformed lines/frames and resynchronises to vsync.
// PARAMETERS
// - WIDTH         160   active pixels per line
// - HEIGHT        144   active lines per frame
// - LINE_TIMEOUT  1023  max cycles from line start to hsync rise before error
// PORTS
// - clk          in   1   system clock, same domain as PPU
// - rst_n        in   1   asynchronous active-low reset
// - lcd_hsync    in   1   high during hblank
// - lcd_vsync    in   1   high during vblank
// - lcd_pixel    in   1   lcd_color valid this cycle
// - lcd_color    in   2   shade 0..3
// - fb_addr      out  13  byte address: buffer_base + (line*WIDTH + x)/4
// - fb_data      out  8   packed byte; first pixel in [7:6], fourth in [1:0]
// - fb_we        out  1   one-cycle write strobe
// - fb_front     out  1   buffer last completed; 0 without LCD_CAPTURE_DOUBLEBUF_EN
// - frame_done   out  1   one-cycle pulse on a clean frame end
// - frame_count  out  8   clean frames captured, wraps 255->0
// - sync_err     out  1   sticky; cleared by reset only
// BEHAVIOUR
// - Reset: all outputs 0; state SEEK; hsync_q = vsync_q = 0; counters 0.
// - Edge detect: hs_rise = lcd_hsync & ~hsync_q; vs_rise/vs_fall likewise, registered.
// - FSM
//   - SEEK: drop pixels; on vs_fall -> LINE, line = 0, x = 0.
//   - LINE: accept pixels; on hs_rise -> HBL.
//   - HBL: on hblank exit (hsync 0, vsync 0) -> LINE with line+1, x = 0.
//     On vs_rise -> frame check.
//   - vs_rise seen in LINE or HBL -> frame check.
// - Frame check: line count must equal HEIGHT and all lines clean.
//   - Clean: frame_done = 1 for 1 cycle; frame_count+1.
//   - Then SEEK; next vs_fall starts the next frame.
// - Pixel accept (LINE, lcd_pixel = 1)
//   - Shift lcd_color into a 6-bit accumulator; x+1.
//   - On the 4th pixel of a group: fb_data = {acc, lcd_color}, fb_addr registered,
//     fb_we = 1 the following cycle.
//   - Write latency is 1 cycle after the 4th pixel.
// - Pixels while x == WIDTH: dropped, sync_err = 1.
//   Pixels in HBL/SEEK: dropped silently.
// - hs_rise with x != WIDTH: sync_err = 1. Any partial group is discarded, never written.
// - line >= HEIGHT on entry to LINE: pixels dropped, sync_err = 1.
//   Frame is not counted; frame_done stays 0.
// - Timeout: cycles in LINE reach LINE_TIMEOUT without hs_rise (e.g. LCD disabled)
//   -> sync_err = 1, state SEEK.
// - hs_rise and vs_rise in the same cycle: vsync takes priority; line is not closed.
// - Async reset mid-frame: immediate return to reset values; capture resumes
//   at the next vs_fall.
// - Address arithmetic: 13-bit, no wrap. Max index 5759 per buffer.
// CONFIGURATION
// - LCD_CAPTURE_DOUBLEBUF_EN defined
//   - Two buffers: back base = 0 or 4096 (fb_addr[12]).
//   - Write into back buffer; on a clean frame end fb_front <= back and back toggles.
//   - Dirty frame: no swap.
//   - Per-buffer index still < 4096 (needs WIDTH*HEIGHT/4 <= 4096, so HEIGHT is reduced
//     or addr widened accordingly; checked by elaboration assertion).
// - Undefined: single buffer at base 0, fb_front tied 0.
// TESTING
// - Clean 160x144 frame, color = x%4 -> 5760 writes, fb_data 8'h1B at addr 0;
//   frame_done once; frame_count = 1; sync_err = 0.
// - Line with 159 pixels -> sync_err = 1 at hs_rise; no frame_done;
//   next clean frame -> frame_count+1.
// - Line with 161 pixels -> 161st dropped, sync_err = 1, no write at addr 40.
// - Hsync/vsync held low for 1100 cycles mid-line -> sync_err = 1, FSM SEEK;
//   no writes until next vs_fall.
// - rst_n low mid-line 50 -> all outputs 0 immediately; following full frame captured cleanly.
// - DOUBLEBUF_EN: two clean frames -> first writes at base 0, fb_front = 0 then 1;
//   dirty third frame -> fb_front unchanged.

Source files
------------

// File: rtl/lcd_frame_capture.sv
// Captures the PPU LCD pixel stream and packs 2bpp pixels four-per-byte into a framebuffer write port.
// Optional double buffering is enabled by defining LCD_CAPTURE_DOUBLEBUF_EN.
module lcd_frame_capture #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 144,
  parameter int LINE_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        fb_front,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        sync_err
);

  localparam int XW  = $clog2(WIDTH + 1);
  localparam int LW  = $clog2(HEIGHT + 2);
  localparam int TW  = $clog2(LINE_TIMEOUT + 1);
  localparam int BPL = WIDTH / 4;
`ifdef LCD_CAPTURE_DOUBLEBUF_EN
  localparam int IW  = 12;
`else
  localparam int IW  = 13;
`endif

  typedef enum logic [1:0] {SEEK, LINE, HBL} state_t;

  state_t          state_q, state_d;
  logic            hsync_q, vsync_q;
  logic [LW-1:0]   line_q, line_d;
  logic [XW-1:0]   x_q, x_d;
  logic [5:0]      acc_q, acc_d;
  logic [TW-1:0]   tout_q, tout_d;
  logic            clean_q, clean_d;
  logic [12:0]     fb_addr_q, fb_addr_d;
  logic [7:0]      fb_data_q, fb_data_d;
  logic            fb_we_q, fb_we_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            sync_err_q, sync_err_d;

  logic            hs_rise, vs_rise, vs_fall;
  logic [IW-1:0]   idx;
  logic [12:0]     wr_addr;

  assign hs_rise = lcd_hsync & ~hsync_q;
  assign vs_rise = lcd_vsync & ~vsync_q;
  assign vs_fall = ~lcd_vsync & vsync_q;
  assign idx     = IW'(line_q) * IW'(BPL) + IW'(x_q >> 2);

`ifdef LCD_CAPTURE_DOUBLEBUF_EN
  logic back_q, back_d, front_q, front_d;

  // Each half of the 8 KiB space holds one frame; the back buffer selects the half.
  assign wr_addr  = {back_q, idx};
  assign fb_front = front_q;

  generate
    if (BPL * HEIGHT > 4096) begin : g_size_chk
      $error("lcd_frame_capture: WIDTH*HEIGHT/4 exceeds 4096 bytes per buffer");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q  <= 1'b0;
      front_q <= 1'b0;
    end else begin
      back_q  <= back_d;
      front_q <= front_d;
    end
  end
`else
  assign wr_addr  = idx;
  assign fb_front = 1'b0;
`endif

  always_comb begin
    logic frame_end;
    frame_end     = 1'b0;
    state_d       = state_q;
    line_d        = line_q;
    x_d           = x_q;
    acc_d         = acc_q;
    tout_d        = tout_q;
    clean_d       = clean_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    fb_we_d       = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    sync_err_d    = sync_err_q;
`ifdef LCD_CAPTURE_DOUBLEBUF_EN
    back_d        = back_q;
    front_d       = front_q;
`endif

    case (state_q)
      SEEK: begin
        if (vs_fall) begin
          state_d = LINE;
          line_d  = '0;
          x_d     = '0;
          acc_d   = '0;
          tout_d  = '0;
          clean_d = 1'b1;
        end
      end
      LINE: begin
        tout_d = tout_q + 1'b1;
        if (vs_rise) begin
          // vsync wins over a coincident hsync: the open line is never closed.
          frame_end = 1'b1;
          state_d   = SEEK;
        end else if (hs_rise) begin
          if (x_q != XW'(WIDTH)) begin
            sync_err_d = 1'b1;
            clean_d    = 1'b0;
          end
          state_d = HBL;
          acc_d   = '0;
          if (line_q <= LW'(HEIGHT)) begin
            line_d = line_q + 1'b1;
          end
        end else if (tout_q == TW'(LINE_TIMEOUT - 1)) begin
          sync_err_d = 1'b1;
          clean_d    = 1'b0;
          state_d    = SEEK;
        end else if (lcd_pixel) begin
          if (line_q >= LW'(HEIGHT) || x_q == XW'(WIDTH)) begin
            sync_err_d = 1'b1;
            clean_d    = 1'b0;
          end else begin
            acc_d = {acc_q[3:0], lcd_color};
            x_d   = x_q + 1'b1;
            if (x_q[1:0] == 2'd3) begin
              fb_we_d   = 1'b1;
              fb_data_d = {acc_q, lcd_color};
              fb_addr_d = wr_addr;
            end
          end
        end
      end
      HBL: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = SEEK;
        end else if (!lcd_hsync && !lcd_vsync) begin
          state_d = LINE;
          x_d     = '0;
          acc_d   = '0;
          tout_d  = '0;
          if (line_q >= LW'(HEIGHT)) begin
            sync_err_d = 1'b1;
            clean_d    = 1'b0;
          end
        end
      end
      default: state_d = SEEK;
    endcase

    if (frame_end && clean_q && line_q == LW'(HEIGHT)) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
`ifdef LCD_CAPTURE_DOUBLEBUF_EN
      front_d       = back_q;
      back_d        = ~back_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEEK;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_q        <= '0;
      x_q           <= '0;
      acc_q         <= '0;
      tout_q        <= '0;
      clean_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      fb_we_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= lcd_hsync;
      vsync_q       <= lcd_vsync;
      line_q        <= line_d;
      x_q           <= x_d;
      acc_q         <= acc_d;
      tout_q        <= tout_d;
      clean_q       <= clean_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      fb_we_q       <= fb_we_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign fb_we       = fb_we_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign sync_err    = sync_err_q;

endmodule
